// File: rtl/im2col_pkg.sv
// Shared state encoding and default widths for the im2col address generator.
package im2col_pkg;

    localparam int TENSOR_W_D = 8;
    localparam int KERNEL_W_D = 4;
    localparam int CHAN_W_D   = 8;
    localparam int STRIDE_W_D = 3;
    localparam int KNUM_W_D   = 8;
    localparam int PAD_W_D    = 2;
    localparam int ADDR_W_D   = 20;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/im2col_addr_gen_if.sv
// Address-pair stream between the generator (master) and the SRAM read side (slave).
interface im2col_addr_gen_if #(
    parameter int ADDR_W = 20
);
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_tensor_addr;
    logic [ADDR_W-1:0] o_weight_addr;
    logic              o_pad;

    modport master (output o_valid, output o_tensor_addr, output o_weight_addr,
                    output o_pad, input i_ready);
    modport slave  (input o_valid, input o_tensor_addr, input o_weight_addr,
                    input o_pad, output i_ready);
endinterface

// File: rtl/im2col_loop_cnt.sv
// Six-level oy/ox/kn/c/ky/kx counter nest; next values are exposed so the top
// can register addresses for the beat that becomes current after the edge.
module im2col_loop_cnt
    import im2col_pkg::*;
#(
    parameter int OD_W     = 11,
    parameter int KNUM_W   = 8,
    parameter int CHAN_W   = 8,
    parameter int KERNEL_W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                adv,
    input  logic [OD_W-1:0]     o_dim,
    input  logic [KNUM_W-1:0]   n_num,
    input  logic [CHAN_W-1:0]   c_num,
    input  logic [KERNEL_W-1:0] k_num,
    output logic [OD_W-1:0]     oy_n,
    output logic [OD_W-1:0]     ox_n,
    output logic [KNUM_W-1:0]   kn_n,
    output logic [CHAN_W-1:0]   c_n,
    output logic [KERNEL_W-1:0] ky_n,
    output logic [KERNEL_W-1:0] kx_n,
    output logic                last
);
    logic [OD_W-1:0]     oy_r, ox_r;
    logic [KNUM_W-1:0]   kn_r;
    logic [CHAN_W-1:0]   c_r;
    logic [KERNEL_W-1:0] ky_r, kx_r;
    logic oy_w, ox_w, kn_w, c_w, ky_w, kx_w;

    assign oy_w = (oy_r == o_dim - OD_W'(1'b1));
    assign ox_w = (ox_r == o_dim - OD_W'(1'b1));
    assign kn_w = (kn_r == n_num - KNUM_W'(1'b1));
    assign c_w  = (c_r  == c_num - CHAN_W'(1'b1));
    assign ky_w = (ky_r == k_num - KERNEL_W'(1'b1));
    assign kx_w = (kx_r == k_num - KERNEL_W'(1'b1));
    assign last = oy_w & ox_w & kn_w & c_w & ky_w & kx_w;

    // Innermost-first carry chain, stepping only on an accepted beat.
    always_comb begin
        oy_n = oy_r; ox_n = ox_r; kn_n = kn_r;
        c_n  = c_r;  ky_n = ky_r; kx_n = kx_r;
        if (clr) begin
            oy_n = '0; ox_n = '0; kn_n = '0;
            c_n  = '0; ky_n = '0; kx_n = '0;
        end else if (adv) begin
            if (!kx_w) kx_n = kx_r + KERNEL_W'(1'b1);
            else begin
                kx_n = '0;
                if (!ky_w) ky_n = ky_r + KERNEL_W'(1'b1);
                else begin
                    ky_n = '0;
                    if (!c_w) c_n = c_r + CHAN_W'(1'b1);
                    else begin
                        c_n = '0;
                        if (!kn_w) kn_n = kn_r + KNUM_W'(1'b1);
                        else begin
                            kn_n = '0;
                            if (!ox_w) ox_n = ox_r + OD_W'(1'b1);
                            else begin
                                ox_n = '0;
                                if (!oy_w) oy_n = oy_r + OD_W'(1'b1);
                                else       oy_n = '0;
                            end
                        end
                    end
                end
            end
        end else begin
            kx_n = kx_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            oy_r <= '0; ox_r <= '0; kn_r <= '0;
            c_r  <= '0; ky_r <= '0; kx_r <= '0;
        end else begin
            oy_r <= oy_n; ox_r <= ox_n; kn_r <= kn_n;
            c_r  <= c_n;  ky_r <= ky_n; kx_r <= kx_n;
        end
    end
endmodule

// File: rtl/im2col_addr_gen.sv
// im2col tensor/weight address-pair generator with start/done and valid/ready.
// Zero padding is compiled in only when the PAD_EN macro is defined.
module im2col_addr_gen
    import im2col_pkg::*;
#(
    parameter int TENSOR_W = TENSOR_W_D,
    parameter int KERNEL_W = KERNEL_W_D,
    parameter int CHAN_W   = CHAN_W_D,
    parameter int STRIDE_W = STRIDE_W_D,
    parameter int KNUM_W   = KNUM_W_D,
    parameter int PAD_W    = PAD_W_D,
    parameter int ADDR_W   = ADDR_W_D
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [TENSOR_W-1:0] tensor_size,
    input  logic [KERNEL_W-1:0] kernel_size,
    input  logic [CHAN_W-1:0]   channels,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [KNUM_W-1:0]   kernel_nums,
    input  logic [PAD_W-1:0]    pad,
    im2col_addr_gen_if.master   bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);
    // SP_W holds T+2P; POS_W adds a bit so a negative row/column wraps above T.
    localparam int SP_W  = TENSOR_W + PAD_W + 1;
    localparam int POS_W = SP_W + 1;

    logic [1:0]          state_r;
    logic [TENSOR_W-1:0] t_r;
    logic [KERNEL_W-1:0] k_r;
    logic [CHAN_W-1:0]   c_r;
    logic [STRIDE_W-1:0] s_r;
    logic [KNUM_W-1:0]   n_r;
    logic [PAD_W-1:0]    p_s;
    logic [SP_W-1:0]     o_dim_r, span_s, odim_s;
    logic [STRIDE_W-1:0] s_safe_s;
    logic                valid_r, done_r, busy_r, err_r, pad_r, pad_s;
    logic [ADDR_W-1:0]   tadr_r, wadr_r, tadr_s, wadr_s;
    logic [POS_W-1:0]    row_s, col_s;
    logic                legal_s, hs_s, last_s;
    logic [SP_W-1:0]     oy_n, ox_n;
    logic [KNUM_W-1:0]   kn_n;
    logic [CHAN_W-1:0]   c_n;
    logic [KERNEL_W-1:0] ky_n, kx_n;

`ifdef PAD_EN
    logic [PAD_W-1:0] p_r;
    assign p_s = p_r;

    // Padding amount latched alongside the rest of the configuration.
    always_ff @(posedge clk) begin
        if (!rstn)                          p_r <= '0;
        else if (state_r == ST_IDLE && start) p_r <= pad;
        else                                p_r <= p_r;
    end
`else
    logic unused_pad;
    assign unused_pad = ^pad;
    assign p_s = '0;
`endif

    assign hs_s     = valid_r & bus.i_ready;
    assign span_s   = SP_W'(t_r) + SP_W'({p_s, 1'b0});
    assign s_safe_s = (s_r == '0) ? STRIDE_W'(1'b1) : s_r;
    assign odim_s   = (span_s - SP_W'(k_r)) / SP_W'(s_safe_s) + SP_W'(1'b1);
    assign legal_s  = (s_r != '0) && (k_r != '0) && (c_r != '0) && (n_r != '0) &&
                      (t_r != '0) && (SP_W'(k_r) <= span_s);

    im2col_loop_cnt #(
        .OD_W(SP_W), .KNUM_W(KNUM_W), .CHAN_W(CHAN_W), .KERNEL_W(KERNEL_W)
    ) u_cnt (
        .clk(clk), .rstn(rstn),
        .clr(state_r == ST_INIT), .adv((state_r == ST_RUN) && hs_s),
        .o_dim(o_dim_r), .n_num(n_r), .c_num(c_r), .k_num(k_r),
        .oy_n(oy_n), .ox_n(ox_n), .kn_n(kn_n), .c_n(c_n), .ky_n(ky_n), .kx_n(kx_n),
        .last(last_s)
    );

    // Address arithmetic for the beat that will be current after this edge.
    always_comb begin
        row_s  = POS_W'(oy_n) * POS_W'(s_r) + POS_W'(ky_n) - POS_W'(p_s);
        col_s  = POS_W'(ox_n) * POS_W'(s_r) + POS_W'(kx_n) - POS_W'(p_s);
        wadr_s = ((ADDR_W'(kn_n) * ADDR_W'(c_r) + ADDR_W'(c_n)) * ADDR_W'(k_r)
                  + ADDR_W'(ky_n)) * ADDR_W'(k_r) + ADDR_W'(kx_n);
        tadr_s = (ADDR_W'(c_n) * ADDR_W'(t_r) + ADDR_W'(row_s)) * ADDR_W'(t_r)
                 + ADDR_W'(col_s);
`ifdef PAD_EN
        pad_s = (row_s >= POS_W'(t_r)) || (col_s >= POS_W'(t_r));
`else
        pad_s = 1'b0;
`endif
        if (pad_s) tadr_s = '0;
        else       tadr_s = tadr_s;
    end

    // Layer FSM, configuration latch and status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            t_r <= '0; k_r <= '0; c_r <= '0; s_r <= '0; n_r <= '0;
            o_dim_r <= '0;
            valid_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0; err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_INIT;
                        busy_r  <= 1'b1;
                        err_r   <= 1'b0;
                        t_r <= tensor_size; k_r <= kernel_size; c_r <= channels;
                        s_r <= stride;      n_r <= kernel_nums;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INIT: begin
                    if (legal_s) begin
                        o_dim_r <= odim_s;
                        valid_r <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (hs_s && last_s) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output address registers; unchanged counters keep them stable under stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tadr_r <= '0; wadr_r <= '0; pad_r <= 1'b0;
        end else if (state_r == ST_INIT || state_r == ST_RUN) begin
            tadr_r <= tadr_s; wadr_r <= wadr_s; pad_r <= pad_s;
        end else begin
            tadr_r <= tadr_r; wadr_r <= wadr_r; pad_r <= pad_r;
        end
    end

    assign bus.o_valid       = valid_r;
    assign bus.o_tensor_addr = tadr_r;
    assign bus.o_weight_addr = wadr_r;
    assign bus.o_pad         = pad_r;
    assign o_busy            = busy_r;
    assign o_done            = done_r;
    assign o_err             = err_r;
endmodule
